// File: rtl/tlc_multi_phase_if.sv
// Request/lamp bus between detector synchronisers and lamp decoders.
// master = controller side, slave = environment side.
interface tlc_multi_phase_if #(
  parameter int N_DIR = 4
) ();
  localparam int CW = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic [N_DIR-1:0]   req;
  logic               flash;
  logic [3*N_DIR-1:0] lights;
  logic [CW-1:0]      cur_dir;
  logic [1:0]         phase;
  logic               done;

  modport master (
    input  req,
    input  flash,
    output lights,
    output cur_dir,
    output phase,
    output done
  );

  modport slave (
    output req,
    output flash,
    input  lights,
    input  cur_dir,
    input  phase,
    input  done
  );
endinterface

// File: rtl/tlc_multi_phase.sv
// N-way round-robin traffic light controller with rest-in-green.
// Optional flash mode enabled by defining FLASH_MODE_EN.
module tlc_multi_phase #(
  parameter int N_DIR    = 4,
  parameter int TW       = 8,
  parameter int T_RED    = 3,
  parameter int T_YELLOW = 4,
  parameter int T_GREEN  = 8
) (
  input  logic clk,
  input  logic rst,
  tlc_multi_phase_if.master bus
);
  localparam int CW = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  localparam logic [1:0] S_ALL_RED = 2'b00;
  localparam logic [1:0] S_GREEN   = 2'b01;
  localparam logic [1:0] S_YELLOW  = 2'b10;
  localparam logic [1:0] S_FLASH   = 2'b11;

  localparam logic [TW-1:0] LD_RED = TW'(T_RED - 1);
  localparam logic [TW-1:0] LD_YEL = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_GRN = TW'(T_GREEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cur_dir_q, cur_dir_d;
  logic [N_DIR-1:0] pend_q, pend_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             done_q, done_d;

  logic [N_DIR-1:0] merged;
  logic [N_DIR-1:0] cur_oh;
  logic [N_DIR-1:0] others;
  logic [N_DIR-1:0] nxt_oh;
  logic [CW-1:0]    nxt_dir;
  logic             found;
  logic             expired;
  logic [TW-1:0]    tmr_dec;
  logic [3*N_DIR-1:0] lights;

`ifdef FLASH_MODE_EN
  logic flash_on_q, flash_on_d;
`else
  logic unused_flash;
  assign unused_flash = bus.flash;
`endif

  // Round-robin scan starting after cur_dir, cur_dir itself last
  always_comb begin
    nxt_dir = cur_dir_q;
    found   = 1'b0;
    for (int k = 1; k <= N_DIR; k++) begin
      int idx;
      idx = (int'(cur_dir_q) + k) % N_DIR;
      if (!found && merged[idx]) begin
        found   = 1'b1;
        nxt_dir = CW'(idx);
      end
    end
  end

  always_comb begin
    merged  = pend_q | bus.req;
    cur_oh  = '0;
    cur_oh[cur_dir_q] = 1'b1;
    nxt_oh  = '0;
    nxt_oh[nxt_dir] = 1'b1;
    others  = merged & ~cur_oh;
    expired = (tmr_q == '0);
    tmr_dec = expired ? '0 : tmr_q - 1'b1;

    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    pend_d    = merged;
    tmr_d     = tmr_dec;
    done_d    = 1'b0;
`ifdef FLASH_MODE_EN
    flash_on_d = flash_on_q;
`endif

    unique case (state_q)
      S_ALL_RED: begin
        if (expired && found) begin
          state_d   = S_GREEN;
          cur_dir_d = nxt_dir;
          tmr_d     = LD_GRN;
          pend_d    = merged & ~nxt_oh;
        end
      end
      S_GREEN: begin
        pend_d = others;
        if (expired && |others) begin
          state_d = S_YELLOW;
          tmr_d   = LD_YEL;
        end
      end
      S_YELLOW: begin
        if (expired) begin
          state_d = S_ALL_RED;
          tmr_d   = LD_RED;
          done_d  = 1'b1;
        end
      end
      S_FLASH: begin
        pend_d = '0;
`ifdef FLASH_MODE_EN
        if (expired) begin
          flash_on_d = ~flash_on_q;
          tmr_d      = LD_YEL;
        end
        if (!bus.flash) begin
          state_d = S_ALL_RED;
          tmr_d   = LD_RED;
        end
`else
        state_d = S_ALL_RED;
        tmr_d   = LD_RED;
`endif
      end
      default: begin
        state_d = S_ALL_RED;
        tmr_d   = LD_RED;
      end
    endcase

`ifdef FLASH_MODE_EN
    if (bus.flash && state_q != S_FLASH) begin
      state_d    = S_FLASH;
      pend_d     = '0;
      tmr_d      = LD_YEL;
      flash_on_d = 1'b1;
      done_d     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ALL_RED;
      cur_dir_q <= '0;
      pend_q    <= '0;
      tmr_q     <= LD_RED;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      pend_q    <= pend_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
    end
  end

`ifdef FLASH_MODE_EN
  always_ff @(posedge clk) begin
    if (rst) flash_on_q <= 1'b0;
    else     flash_on_q <= flash_on_d;
  end
`endif

  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      lights[3*i +: 3] = 3'b100;
    end
    unique case (state_q)
      S_GREEN:  lights[3*int'(cur_dir_q) +: 3] = 3'b001;
      S_YELLOW: lights[3*int'(cur_dir_q) +: 3] = 3'b010;
      S_FLASH: begin
`ifdef FLASH_MODE_EN
        for (int i = 0; i < N_DIR; i++) begin
          lights[3*i +: 3] = flash_on_q ? 3'b010 : 3'b000;
        end
`endif
      end
      default: ;
    endcase
  end

  assign bus.lights  = lights;
  assign bus.cur_dir = cur_dir_q;
  assign bus.phase   = state_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_tlc_multi_phase.sv
// Directed bench for tlc_multi_phase, default build (4 dirs).
// Expected values are hand-derived lamp/phase constants.
module tb_tlc_multi_phase;
  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] ALL_R  = 12'b100_100_100_100;
  localparam logic [11:0] G2     = 12'b100_001_100_100;
  localparam logic [11:0] Y2     = 12'b100_010_100_100;
  localparam logic [11:0] G0     = 12'b100_100_100_001;
  localparam logic [11:0] G1     = 12'b100_100_001_100;
  localparam logic [11:0] Y1     = 12'b100_100_010_100;

  tlc_multi_phase_if #(.N_DIR(4)) bus ();

  tlc_multi_phase #(
    .N_DIR(4), .TW(8), .T_RED(3),
    .T_YELLOW(4), .T_GREEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  int nonred;
  logic [1:0] seq [5];

  initial begin
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3;
    seq[3] = 2'd0; seq[4] = 2'd1;
    rst = 1'b1;
    bus.req = '0;
    bus.flash = 1'b0;
    tick(2);

    // reset state, single request on dir2
    rst = 1'b0;
    bus.req = 4'b0100;
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_lights", 32'(bus.lights), 32'(ALL_R));
    chk("rst_dir", 32'(bus.cur_dir), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    tick();
    bus.req = '0;
    chk("ar1", 32'(bus.phase), 32'd0);
    tick();
    chk("ar2", 32'(bus.phase), 32'd0);
    tick();
    chk("g2_phase", 32'(bus.phase), 32'd1);
    chk("g2_dir", 32'(bus.cur_dir), 32'd2);
    chk("g2_lights", 32'(bus.lights), 32'(G2));
    tick(7);
    chk("g2_min", 32'(bus.lights), 32'(G2));
    tick(20);
    chk("g2_rest", 32'(bus.lights), 32'(G2));
    chk("g2_nodone", 32'(bus.done), 32'd0);

    // pulse req[0] while dir2 rests
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    chk("y2_first", 32'(bus.lights), 32'(Y2));
    tick(3);
    chk("y2_last", 32'(bus.lights), 32'(Y2));
    chk("y2_dir", 32'(bus.cur_dir), 32'd2);
    tick();
    chk("y2_done", 32'(bus.done), 32'd1);
    chk("ar_after_y", 32'(bus.lights), 32'(ALL_R));
    tick();
    chk("done_once", 32'(bus.done), 32'd0);
    tick();
    chk("ar_3rd", 32'(bus.phase), 32'd0);
    tick();
    chk("g0_lights", 32'(bus.lights), 32'(G0));
    chk("g0_dir", 32'(bus.cur_dir), 32'd0);

    // all requests held: rr 1,2,3,0,1
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    rst = 1'b0;
    tick(3);
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 32'(bus.cur_dir), 32'(seq[g]));
      chk("rr_green", 32'(bus.phase), 32'd1);
      tick(7);
      chk("rr_green8", 32'(bus.phase), 32'd1);
      tick();
      chk("rr_yel1", 32'(bus.phase), 32'd2);
      tick(3);
      chk("rr_yel4", 32'(bus.phase), 32'd2);
      tick();
      chk("rr_ar1", 32'(bus.phase), 32'd0);
      chk("rr_done", 32'(bus.done), 32'd1);
      tick(2);
      chk("rr_ar3", 32'(bus.phase), 32'd0);
      tick();
    end

    // reset mid-yellow of dir1 with dir3 pending
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick(2);
    chk("m_g1", 32'(bus.lights), 32'(G1));
    tick();
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    tick(6);
    chk("m_y1", 32'(bus.lights), 32'(Y1));
    tick(2);
    rst = 1'b1;
    tick();
    chk("m_rst_l", 32'(bus.lights), 32'(ALL_R));
    chk("m_rst_p", 32'(bus.phase), 32'd0);
    chk("m_rst_d", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick(30);
    chk("m_no_d3", 32'(bus.lights), 32'(ALL_R));

    // random requests: at most one non-red, no flash phase
    for (int c = 0; c < 2000; c++) begin
      bus.req = 4'($urandom_range(0, 15));
      tick();
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus.lights[3*i +: 3] != 3'b100) nonred++;
      end
      chk("inv_one", 32'(nonred <= 1), 32'd1);
      chk("inv_noflash", 32'(bus.phase == 2'b11), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
